// File: rtl/cpu_pkg.sv
// Shared types and widths for the 5-stage LEGv8 pipeline.
// Condition codes and the NZVC flag layout live here.
package cpu_pkg;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_HS = 4'h2,
        COND_LO = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator over an NZVC flag set.
// Shared between the EX/MEM boundary and the IF-stage predictor.
module cond_eval
    import cpu_pkg::*;
(
    input  flags_t flags,
    input  cond_e  cond,
    output logic   taken
);

    always_comb begin
        taken = 1'b1;
        unique case (cond)
            COND_EQ: taken = flags.z;
            COND_NE: taken = !flags.z;
            COND_HS: taken = flags.c;
            COND_LO: taken = !flags.c;
            COND_MI: taken = flags.n;
            COND_PL: taken = !flags.n;
            COND_VS: taken = flags.v;
            COND_VC: taken = !flags.v;
            COND_HI: taken = flags.c && !flags.z;
            COND_LS: taken = !(flags.c && !flags.z);
            COND_GE: taken = (flags.n == flags.v);
            COND_LT: taken = (flags.n != flags.v);
            COND_GT: taken = !flags.z && (flags.n == flags.v);
            COND_LE: taken = !(!flags.z && (flags.n == flags.v));
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the architectural NZVC flags
// and registered B.cond resolution for the MEM-stage redirect.
module ex_mem_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_neg,
    input  logic              ex_zero,
    input  logic              ex_ovf,
    input  logic              ex_cout,
    input  logic              ex_set_flags,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_is_bcond,
    input  logic [3:0]        ex_cond,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_branch_taken,
    output logic [3:0]        flags
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              rw_q, rw_d;
    logic              mr_q, mr_d;
    logic              mw_q, mw_d;
    logic              bt_q, bt_d;
    flags_t            flags_q, flags_d;
    logic              cond_true;

    // Evaluated on committed flags only; no bypass from ex_* flags.
    cond_eval u_cond_eval (
        .flags (flags_q),
        .cond  (cond_e'(ex_cond)),
        .taken (cond_true)
    );

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        store_d  = store_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        bt_d     = bt_q;
        flags_d  = flags_q;
        if (flush) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
            bt_d    = 1'b0;
        end else if (!stall) begin
            valid_d  = ex_valid;
            result_d = ex_result;
            store_d  = ex_store_data;
            rd_d     = ex_rd;
            rw_d     = ex_valid && ex_reg_write;
            mr_d     = ex_valid && ex_mem_read;
            mw_d     = ex_valid && ex_mem_write;
            bt_d     = ex_valid && ex_is_bcond && cond_true;
            if (ex_valid && ex_set_flags) begin
                flags_d = '{n: ex_neg, z: ex_zero,
                            v: ex_ovf, c: ex_cout};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            bt_q     <= 1'b0;
            flags_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            bt_q     <= bt_d;
            flags_q  <= flags_d;
        end
    end

    assign mem_valid        = valid_q;
    assign mem_result       = result_q;
    assign mem_store_data   = store_q;
    assign mem_rd           = rd_q;
    assign mem_reg_write    = rw_q;
    assign mem_mem_read     = mr_q;
    assign mem_mem_write    = mw_q;
    assign mem_branch_taken = bt_q;
    assign flags            = flags_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed cases plus random
// traffic checked against a cycle-level behavioural model.
module tb_ex_mem_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [63:0] ex_result;
    logic        ex_neg;
    logic        ex_zero;
    logic        ex_ovf;
    logic        ex_cout;
    logic        ex_set_flags;
    logic [63:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_is_bcond;
    logic [3:0]  ex_cond;
    logic        mem_valid;
    logic [63:0] mem_result;
    logic [63:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        mem_branch_taken;
    logic [3:0]  flags;

    ex_mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .ex_valid         (ex_valid),
        .ex_result        (ex_result),
        .ex_neg           (ex_neg),
        .ex_zero          (ex_zero),
        .ex_ovf           (ex_ovf),
        .ex_cout          (ex_cout),
        .ex_set_flags     (ex_set_flags),
        .ex_store_data    (ex_store_data),
        .ex_rd            (ex_rd),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_is_bcond      (ex_is_bcond),
        .ex_cond          (ex_cond),
        .mem_valid        (mem_valid),
        .mem_result       (mem_result),
        .mem_store_data   (mem_store_data),
        .mem_rd           (mem_rd),
        .mem_reg_write    (mem_reg_write),
        .mem_mem_read     (mem_mem_read),
        .mem_mem_write    (mem_mem_write),
        .mem_branch_taken (mem_branch_taken),
        .flags            (flags)
    );

    typedef struct {
        logic        valid;
        logic [63:0] result;
        logic        n, z, v, c;
        logic        setf;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw;
        logic        bcond;
        logic [3:0]  cond;
        logic        stall;
        logic        flush;
    } in_t;

    typedef struct {
        logic        valid;
        logic [63:0] result;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw, bt;
        logic [3:0]  flags;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: LEGv8 condition table, pairs differ only by inversion.
    function automatic logic cond_true(input logic [3:0] f,
                                       input logic [3:0] c);
        logic n, z, v, cy, b;
        n  = f[3];
        z  = f[2];
        v  = f[1];
        cy = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: return 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    function automatic in_t blank();
        in_t s;
        s.valid = 0; s.result = '0;
        s.n = 0; s.z = 0; s.v = 0; s.c = 0;
        s.setf = 0; s.sd = '0; s.rd = '0;
        s.rw = 0; s.mr = 0; s.mw = 0;
        s.bcond = 0; s.cond = '0;
        s.stall = 0; s.flush = 0;
        return s;
    endfunction

    function automatic in_t rand_in();
        in_t s;
        s.valid  = ($urandom_range(0, 3) != 0);
        s.result = {$urandom, $urandom};
        s.n = $urandom_range(0, 1);
        s.z = $urandom_range(0, 1);
        s.v = $urandom_range(0, 1);
        s.c = $urandom_range(0, 1);
        s.setf  = $urandom_range(0, 1);
        s.sd    = {$urandom, $urandom};
        s.rd    = 5'($urandom);
        s.rw    = $urandom_range(0, 1);
        s.mr    = $urandom_range(0, 1);
        s.mw    = $urandom_range(0, 1);
        s.bcond = $urandom_range(0, 1);
        s.cond  = 4'($urandom);
        s.stall = ($urandom_range(0, 4) == 0);
        s.flush = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    task automatic clear_model();
        m.valid = 0; m.result = '0; m.sd = '0; m.rd = '0;
        m.rw = 0; m.mr = 0; m.mw = 0; m.bt = 0;
        m.flags = 4'b0000;
    endtask

    task automatic step(input in_t s);
        @(negedge clk);
        ex_valid      = s.valid;
        ex_result     = s.result;
        ex_neg        = s.n;
        ex_zero       = s.z;
        ex_ovf        = s.v;
        ex_cout       = s.c;
        ex_set_flags  = s.setf;
        ex_store_data = s.sd;
        ex_rd         = s.rd;
        ex_reg_write  = s.rw;
        ex_mem_read   = s.mr;
        ex_mem_write  = s.mw;
        ex_is_bcond   = s.bcond;
        ex_cond       = s.cond;
        stall         = s.stall;
        flush         = s.flush;
        if (s.flush) begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.bt = 0;
        end else if (!s.stall) begin
            m.bt     = s.valid && s.bcond && cond_true(m.flags, s.cond);
            m.valid  = s.valid;
            m.result = s.result;
            m.sd     = s.sd;
            m.rd     = s.rd;
            m.rw     = s.valid && s.rw;
            m.mr     = s.valid && s.mr;
            m.mw     = s.valid && s.mw;
            if (s.valid && s.setf)
                m.flags = {s.n, s.z, s.v, s.c};
        end
        q.push_back(m);
    endtask

    task automatic check_all(input exp_t e, input string tag);
        check({tag, ".mem_valid"}, 64'(mem_valid), 64'(e.valid));
        check({tag, ".mem_result"}, mem_result, e.result);
        check({tag, ".mem_store_data"}, mem_store_data, e.sd);
        check({tag, ".mem_rd"}, 64'(mem_rd), 64'(e.rd));
        check({tag, ".mem_reg_write"}, 64'(mem_reg_write), 64'(e.rw));
        check({tag, ".mem_mem_read"}, 64'(mem_mem_read), 64'(e.mr));
        check({tag, ".mem_mem_write"}, 64'(mem_mem_write), 64'(e.mw));
        check({tag, ".mem_branch_taken"}, 64'(mem_branch_taken), 64'(e.bt));
        check({tag, ".flags"}, 64'(flags), 64'(e.flags));
    endtask

    // Monitor: one registered result per edge, popped just after it.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check_all(e, "edge");
        end
    end

    initial begin
        in_t s;
        exp_t z;
        reset = 0;
        ex_valid = 0; ex_result = '0; ex_neg = 0; ex_zero = 0;
        ex_ovf = 0; ex_cout = 0; ex_set_flags = 0;
        ex_store_data = '0; ex_rd = '0; ex_reg_write = 0;
        ex_mem_read = 0; ex_mem_write = 0; ex_is_bcond = 0;
        ex_cond = '0; stall = 0; flush = 0;
        clear_model();
        z = m;
        #1 reset = 1;
        #1 check_all(z, "reset");
        @(negedge clk) reset = 0;

        // SUBS result 0: Z and C set, then EQ / NE.
        s = blank(); s.valid = 1; s.setf = 1; s.z = 1; s.c = 1;
        s.rw = 1; s.rd = 5'd3;
        step(s);
        s = blank(); s.valid = 1; s.bcond = 1; s.cond = 4'h0;
        step(s);
        s.cond = 4'h1;
        step(s);

        // Signed compare with N=1, V=0.
        s = blank(); s.valid = 1; s.setf = 1; s.n = 1;
        step(s);
        foreach (s.cond[i]) ;
        s = blank(); s.valid = 1; s.bcond = 1;
        s.cond = 4'hB; step(s);
        s.cond = 4'hA; step(s);
        s.cond = 4'hC; step(s);
        s.cond = 4'hE; step(s);

        // Stall with pending flag setter, then release.
        s = blank(); s.valid = 1; s.setf = 1; s.v = 1; s.c = 1;
        s.rw = 1; s.result = 64'h1234; s.stall = 1;
        repeat (3) step(s);
        s.stall = 0;
        step(s);

        // Flush beats stall.
        s = blank(); s.valid = 1; s.rw = 1; s.setf = 1; s.n = 1;
        s.z = 1; s.stall = 1; s.flush = 1;
        step(s);

        // Datapath corner values, then same fields with valid low.
        s = blank(); s.valid = 1;
        s.result = 64'h8000_0000_0000_0000;
        s.sd = 64'hDEAD_BEEF_CAFE_F00D;
        s.rd = 5'd31; s.mw = 1;
        step(s);
        s.valid = 0;
        step(s);

        for (int i = 0; i < 400; i++) step(rand_in());

        // Async reset mid-cycle while stalled with the stage loaded.
        s = blank(); s.valid = 1; s.rw = 1; s.mr = 1; s.setf = 1;
        s.n = 1; s.z = 1; s.v = 1; s.c = 1; s.result = '1; s.rd = 5'd7;
        step(s);
        s.stall = 1;
        step(s);
        @(posedge clk);
        #3 reset = 1;
        #1 check_all(z, "async_reset");
        clear_model();
        @(posedge clk);
        #2 check_all(z, "reset_held");
        @(negedge clk) reset = 0;

        for (int i = 0; i < 100; i++) step(rand_in());

        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drain", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
